// File: rtl/sibling_path_sig_packer.sv
// sibling_path_sig_packer
// Captures tree-seed words from the seed-sibling-path stage, rebases each
// word to its absolute signature-RAM address (base + e*W + word index) and
// buffers it in a small FIFO so the signature-RAM arbiter can stall writes.
// Pulses o_done once all TAU sibling paths have been written out.
// Optional feature macro: SIBLING_WORD_CHECK_EN (per-path word-count check
// driving o_len_err; without it o_len_err is tied low).
`timescale 1ns/1ps
module sibling_path_sig_packer #(
  parameter PARAMETER_SET   = "L1",
  parameter int TAU         = 17,
  parameter int D_HYPERCUBE = 8,
  parameter int W           = D_HYPERCUBE *
                              ((PARAMETER_SET == "L5") ? 256 :
                               (PARAMETER_SET == "L3") ? 192 : 128) / 32,
  parameter int SIG_BASE_ADDR = 0,
  parameter int SIG_ADDR_W    = 12,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [31:0]           i_tree_seed,
  input  logic                  i_tree_seed_valid,
  input  logic [$clog2(W)-1:0]  i_tree_seed_addr,
  input  logic                  i_path_done,
  output logic                  o_sig_wen,
  output logic [SIG_ADDR_W-1:0] o_sig_addr,
  output logic [31:0]           o_sig_data,
  input  logic                  i_sig_ready,
  output logic [4:0]            o_iter,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic                  o_len_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [SIG_ADDR_W-1:0] addr;
    logic [31:0]           data;
  } wr_t;

  state_t          state, state_nxt;
  logic [4:0]      e;
  wr_t             mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt;
  logic            push_req, push, pop, full, drop, last_path;
  wr_t             push_wr;

  // Only RUN accepts words; a full FIFO still accepts if the head leaves this cycle.
  assign push_req  = (state == RUN) && i_tree_seed_valid;
  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign pop       = o_sig_wen && i_sig_ready;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign last_path = (e == 5'(TAU - 1));

  // Rebase uses the iteration in effect at the push, so a word arriving with
  // i_path_done still belongs to the old path.
  assign push_wr.addr = SIG_ADDR_W'(SIG_BASE_ADDR + int'(e) * W + int'(i_tree_seed_addr));
  assign push_wr.data = i_tree_seed;

  // FIFO storage and pointers; cleared on reset so all outputs start at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_wr;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Iteration counter and sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      e          <= '0;
      o_overflow <= 1'b0;
    end else if (state == IDLE && i_start) begin
      e          <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (drop) o_overflow <= 1'b1;
      if (state == RUN && i_path_done && !last_path) e <= e + 1'b1;
    end
  end

`ifdef SIBLING_WORD_CHECK_EN
  logic [15:0] wcnt, wcnt_nxt;
  assign wcnt_nxt = wcnt + {15'b0, i_tree_seed_valid};

  // Per-path word count; the word coinciding with i_path_done still counts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wcnt      <= '0;
      o_len_err <= 1'b0;
    end else if (state == IDLE && i_start) begin
      wcnt      <= '0;
      o_len_err <= 1'b0;
    end else if (state == RUN) begin
      if (i_path_done) begin
        wcnt <= '0;
        if (wcnt_nxt != 16'(W)) o_len_err <= 1'b1;
      end else begin
        wcnt <= wcnt_nxt;
      end
    end
  end
`else
  assign o_len_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (i_path_done && last_path) state_nxt = DRAIN;
      DRAIN:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: write port straight from the registered FIFO head.
  always_comb begin
    o_done     = (state == DONE);
    o_iter     = e;
    o_sig_wen  = (cnt != '0);
    o_sig_addr = mem[rd_ptr].addr;
    o_sig_data = mem[rd_ptr].data;
  end

endmodule

// File: tb/tb_sibling_path_sig_packer.sv
// Directed bench for sibling_path_sig_packer (L1: TAU=17, W=32, depth 8).
// A scoreboard queue holds expected writes; a small occupancy model decides
// which words a full FIFO must drop.
`timescale 1ns/1ps
module tb_sibling_path_sig_packer;

  localparam int TAU = 17;
  localparam int W   = 32;

  logic        clk = 1'b0;
  logic        rst, start, valid, path_done, ready;
  logic [31:0] data;
  logic [4:0]  addr;
  logic        o_sig_wen, o_done, o_overflow, o_len_err;
  logic [11:0] o_sig_addr;
  logic [31:0] o_sig_data;
  logic [4:0]  o_iter;

  sibling_path_sig_packer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_tree_seed(data), .i_tree_seed_valid(valid), .i_tree_seed_addr(addr),
    .i_path_done(path_done),
    .o_sig_wen(o_sig_wen), .o_sig_addr(o_sig_addr), .o_sig_data(o_sig_data),
    .i_sig_ready(ready),
    .o_iter(o_iter), .o_done(o_done), .o_overflow(o_overflow), .o_len_err(o_len_err)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int d; } exp_t;
  exp_t q[$];
  int   checks = 0, errors = 0;
  int   nwrites = 0, ndone = 0, occ = 0, cur_e = 0, cur_a = 0;
  bit   in_run = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference occupancy: pop when non-empty and ready; a push into a full
  // FIFO without a pop is dropped.
  task automatic tick();
    bit pop;
    pop = (occ > 0) && ready;
    if (valid && in_run) begin
      if (occ == 8 && !pop) begin
        // dropped word: no write expected
      end else begin
        q.push_back('{a: cur_e * W + cur_a, d: (cur_e << 8) | cur_a});
        occ++;
      end
    end
    if (pop) occ--;
    @(posedge clk); #1;
  endtask

  // Write monitor: scoreboard, hold-while-stalled, done timing.
  bit          stalled = 0;
  logic [11:0] held_a;
  logic [31:0] held_d;
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (stalled && o_sig_wen) begin
        chk("hold_addr", 64'(o_sig_addr), 64'(held_a));
        chk("hold_data", 64'(o_sig_data), 64'(held_d));
      end
      stalled = o_sig_wen && !ready;
      held_a  = o_sig_addr;
      held_d  = o_sig_data;
      if (o_sig_wen && ready) begin
        nwrites++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_write: got addr %0h expected no write", o_sig_addr);
        end else begin
          x = q.pop_front();
          checks--;
          chk("wr_addr", 64'(o_sig_addr), 64'(x.a));
          chk("wr_data", 64'(o_sig_data), 64'(x.d));
        end
      end
      if (o_done) begin
        ndone++;
        chk("done_q_empty", 64'(q.size()), 64'(0));
        chk("done_wen", 64'(o_sig_wen), 64'(0));
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_wen"},  64'(o_sig_wen),  64'(0));
    chk({tag, "_addr"}, 64'(o_sig_addr), 64'(0));
    chk({tag, "_data"}, 64'(o_sig_data), 64'(0));
    chk({tag, "_iter"}, 64'(o_iter),     64'(0));
    chk({tag, "_done"}, 64'(o_done),     64'(0));
    chk({tag, "_ovf"},  64'(o_overflow), 64'(0));
    chk({tag, "_len"},  64'(o_len_err),  64'(0));
  endtask

  // One signature: optional short path, optional ready stall on one path,
  // optional abort after a number of words (no done wait then).
  task automatic send_sig(input int short_e, input int stall_e, input int s_lo,
                          input int s_hi, input int abort_at);
    int sent = 0;
    int n, d0;
    start = 1; tick(); start = 0; in_run = 1;
    for (int e = 0; e < TAU; e++) begin
      n = (e == short_e) ? W - 1 : W;
      for (int a = 0; a < n; a++) begin
        cur_e = e; cur_a = a;
        valid = 1; addr = 5'(a); data = 32'((e << 8) | a);
        path_done = (a == n - 1);
        ready = !(e == stall_e && a >= s_lo && a < s_hi);
        tick();
        sent++;
        if (sent == abort_at) begin
          valid = 0; path_done = 0; ready = 1;
          return;
        end
      end
      chk("iter", 64'(o_iter), 64'((e < TAU - 1) ? e + 1 : TAU - 1));
    end
    valid = 0; path_done = 0; ready = 1; in_run = 0;
    d0 = ndone;
    for (int i = 0; i < 40 && ndone == d0; i++) tick();
    repeat (3) tick();
    chk("done_once", 64'(ndone), 64'(d0 + 1));
  endtask

  initial begin
    int w0, d0;
    rst = 1; start = 0; valid = 0; path_done = 0; ready = 1; data = '0; addr = '0;
    repeat (2) @(posedge clk); #1;
    check_zero("reset");
    rst = 0; tick();

    // Nominal L1 run: 544 writes at 0..543, path-end word lands at e*32+31.
    w0 = nwrites;
    send_sig(-1, -1, 0, 0, -1);
    chk("nom_writes", 64'(nwrites - w0), 64'(544));
    chk("nom_ovf",    64'(o_overflow),   64'(0));
    chk("nom_len",    64'(o_len_err),    64'(0));
    chk("nom_iter",   64'(o_iter),       64'(16));

    // Backpressure: 6 stalled cycles mid-burst, FIFO peaks at 7, no drops.
    w0 = nwrites;
    send_sig(-1, 0, 10, 16, -1);
    chk("bp_writes", 64'(nwrites - w0), 64'(544));
    chk("bp_ovf",    64'(o_overflow),   64'(0));

    // Overflow: 10 words with ready low from empty -> words 8,9 dropped.
    w0 = nwrites;
    send_sig(-1, 0, 0, 10, -1);
    chk("ovf_writes", 64'(nwrites - w0), 64'(542));
    chk("ovf_flag",   64'(o_overflow),   64'(1));

    // Short path (31 words) on e=3.
    w0 = nwrites;
    send_sig(3, -1, 0, 0, -1);
    chk("short_writes", 64'(nwrites - w0), 64'(543));
    chk("short_ovf",    64'(o_overflow),   64'(0));
`ifdef SIBLING_WORD_CHECK_EN
    chk("short_len", 64'(o_len_err), 64'(1));
`else
    chk("short_len", 64'(o_len_err), 64'(0));
`endif

    // Reset after 100 words: everything clears, no done, restart from base.
    send_sig(-1, -1, 0, 0, 100);
    d0 = ndone;
    rst = 1; #1;
    check_zero("midrst");
    q.delete(); occ = 0; in_run = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0; tick(); tick();
    chk("midrst_nodone", 64'(ndone), 64'(d0));
    w0 = nwrites;
    send_sig(-1, -1, 0, 0, -1);
    chk("rerun_writes", 64'(nwrites - w0), 64'(544));
    chk("rerun_q_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sibling_path_sig_packer.md
# sibling_path_sig_packer

Downstream consumer of the seed-sibling-path stage in the SDitH signing datapath. It captures the 32-bit tree-seed words streamed for each of the TAU iterations and rebases each word to its absolute location in the signature RAM. Words are buffered in a small FIFO so the signature-RAM arbiter can stall writes without losing seeds. It pulses done once all TAU sibling paths are written.

## Interface
- PARAMETER_SET, "L1": selects LAMBDA = 128 / 192 / 256 for L1 / L3 / L5.
- TAU, 17: number of iterations (sibling paths) per signature.
- D_HYPERCUBE, 8: seeds per sibling path.
- W, D_HYPERCUBE*LAMBDA/32: words per path (32 / 48 / 64).
- SIG_BASE_ADDR, 0: signature-RAM word address of the first path word.
- SIG_ADDR_W, 12: signature-RAM address width.
- FIFO_DEPTH, 8: buffer entries; must be a power of two.
- i_clk, in, 1: clock; one clock domain.
- i_rst, in, 1: asynchronous, active-high reset.
- i_start, in, 1: starts a new signature; sampled only in IDLE.
- i_tree_seed, in, 32: seed word from the sibling-path stage.
- i_tree_seed_valid, in, 1: word valid. There is no backpressure to the producer.
- i_tree_seed_addr, in, `CLOG2(W): word index within the current path.
- i_path_done, in, 1: 1-cycle pulse marking the end of the current iteration's path.
- o_sig_wen, out, 1: write request; high whenever the FIFO is non-empty.
- o_sig_addr, out, SIG_ADDR_W: SIG_BASE_ADDR + e*W + word index.
- o_sig_data, out, 32: seed word.
- i_sig_ready, in, 1: arbiter grant. A write completes on o_sig_wen && i_sig_ready.
- o_iter, out, 5: current iteration e.
- o_done, out, 1: 1-cycle pulse when the signature is complete.
- o_overflow, out, 1: sticky; a word arrived while the FIFO was full.
- o_len_err, out, 1: sticky word-count error (see Configuration).

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_start moves to RUN and clears e, the word counter, o_overflow and o_len_err.
  - i_tree_seed_valid and i_path_done are ignored.
- RUN:
  - Each valid word pushes {SIG_BASE_ADDR + e*W + i_tree_seed_addr, i_tree_seed}. The address is computed with the e in effect at the push.
  - On i_path_done with e < TAU-1: e increments.
  - On i_path_done with e == TAU-1: go to DRAIN. e holds at TAU-1.
  - If valid and i_path_done occur in the same cycle, the word belongs to the old e.
- DRAIN:
  - New valid words are ignored.
  - When the FIFO is empty, go to DONE.
- DONE: assert o_done for one cycle, then return to IDLE.
- i_start outside IDLE is ignored.
- FIFO behaviour:
  - Pop on o_sig_wen && i_sig_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - A push to a full FIFO with no simultaneous pop drops the word and sets o_overflow. o_overflow stays set until i_start or reset.
- Address arithmetic is modulo 2^SIG_ADDR_W. Callers must ensure SIG_BASE_ADDR + TAU*W ≤ 2^SIG_ADDR_W.

## Timing
- Every output resets to 0, and the state resets to IDLE.
- Push-to-write latency is 1 cycle: a word pushed at edge N appears on o_sig_* after edge N. The outputs are registered from the FIFO head.
- The FIFO holds o_sig_addr and o_sig_data stable while o_sig_wen is high and i_sig_ready is low.
- Throughput is one word per cycle when i_sig_ready stays high.
- o_done rises exactly 1 cycle after the last pop is observed with the FIFO empty.
- Reset mid-operation clears the FIFO and all counters. Buffered words are discarded and no o_done is produced.

## Configuration
- Macro SIBLING_WORD_CHECK_EN defined:
  - A per-path counter increments on every accepted valid word in RUN.
  - On i_path_done, if count ≠ W, set o_len_err.
  - The counter clears after i_path_done.
- Macro not defined: the counter is absent and o_len_err is tied to 0.

## Test plan
- Nominal L1 run: i_start, then 17 paths of 32 words each (addr 0..31, data = e<<8|addr) with i_sig_ready=1 → 544 writes at addresses 0..543 with matching data; o_done once; o_overflow=0 and o_len_err=0.
- Backpressure: i_sig_ready low for 6 cycles during a 32-word burst → no drops, ordered addresses, o_sig_* stable while stalled.
- Overflow: i_sig_ready low for 10 consecutive words → exactly 2 words dropped, o_overflow=1, 8 words written after ready returns.
- Boundary: valid with addr 31 and i_path_done in the same cycle for e=0 → that word is written at address 31 and the next path starts at 32.
- With SIBLING_WORD_CHECK_EN: a path with 31 words → o_len_err=1. Without the macro, o_len_err stays 0.
- Reset mid-run after 100 words: assert i_rst → all outputs 0; a new i_start writes again from SIG_BASE_ADDR.
